// File: rtl/audio_codec_serializer.sv
// I2S-slave codec serializer: derives BCLK/LRCK from clk, shifts DAC samples out and ADC samples in.
// Define LEFT_JUSTIFIED_EN for left-justified framing instead of I2S one-bit delay.
module audio_codec_serializer #(
    parameter int BCLK_DIV    = 4,
    parameter int SLOT_BITS   = 32,
    parameter int SAMPLE_BITS = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [SAMPLE_BITS-1:0] sample_in_l,
    input  logic [SAMPLE_BITS-1:0] sample_in_r,
    output logic                   sample_req,
    output logic                   sample_end,
    output logic [SAMPLE_BITS-1:0] adc_l,
    output logic [SAMPLE_BITS-1:0] adc_r,
    output logic                   aud_bclk,
    output logic                   aud_daclrck,
    output logic                   aud_adclrck,
    output logic                   aud_dacdat,
    input  logic                   aud_adcdat
);

    localparam int DW = $clog2(BCLK_DIV);
    localparam int BW = $clog2(2 * SLOT_BITS);
`ifdef LEFT_JUSTIFIED_EN
    localparam int OFF = 0;
`else
    localparam int OFF = 1;
`endif
    localparam logic [DW-1:0] DIV_LAST  = DW'(BCLK_DIV - 1);
    localparam logic [DW-1:0] DIV_HALF  = DW'(BCLK_DIV / 2);
    localparam logic [BW-1:0] BIT_LAST  = BW'(2 * SLOT_BITS - 1);
    localparam logic [BW-1:0] SLOT      = BW'(SLOT_BITS);
    localparam logic [BW-1:0] POS_FIRST = BW'(OFF);
    localparam logic [BW-1:0] POS_END   = BW'(OFF + SAMPLE_BITS);
    localparam logic [SAMPLE_BITS-1:0] MSB = {1'b1, {(SAMPLE_BITS-1){1'b0}}};

    function automatic logic [BW-1:0] slot_pos(input logic [BW-1:0] b);
        slot_pos = (b >= SLOT) ? b - SLOT : b;
    endfunction

    function automatic logic in_window(input logic [BW-1:0] p);
        in_window = (p >= POS_FIRST) && (p < POS_END);
    endfunction

    // Data bit for a slot position, MSB first starting at POS_FIRST.
    function automatic logic word_bit(input logic [SAMPLE_BITS-1:0] w, input logic [BW-1:0] p);
        logic [BW-1:0] rel;
        rel      = p - POS_FIRST;
        word_bit = in_window(p) && (|(w & (MSB >> rel)));
    endfunction

    logic [DW-1:0]          div_cnt, div_nxt;
    logic [BW-1:0]          bit_cnt, bit_nxt, pos_nxt, pos_cur;
    logic                   fe, frame_start, rise_cap, dac_nxt, lrck;
    logic [SAMPLE_BITS-1:0] hold_l, hold_r, shift_l, shift_r, word_l;

    assign fe          = (div_cnt == DIV_LAST);
    assign div_nxt     = fe ? '0 : div_cnt + 1'b1;
    assign bit_nxt     = !fe ? bit_cnt : (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
    assign frame_start = fe && (bit_nxt == '0);
    assign pos_nxt     = slot_pos(bit_nxt);
    assign pos_cur     = slot_pos(bit_cnt);

    // At frame start the hold register is loaded this same edge, so bypass it.
    assign word_l      = frame_start ? sample_in_l : hold_l;
    assign dac_nxt     = word_bit((bit_nxt >= SLOT) ? hold_r : word_l, pos_nxt);
    assign rise_cap    = (div_cnt == DIV_HALF) && in_window(pos_cur);

    assign aud_daclrck = lrck;
    assign aud_adclrck = lrck;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt    <= '0;
            bit_cnt    <= '0;
            aud_bclk   <= 1'b0;
            lrck       <= 1'b0;
            aud_dacdat <= 1'b0;
            sample_req <= 1'b0;
            sample_end <= 1'b0;
            hold_l     <= '0;
            hold_r     <= '0;
            shift_l    <= '0;
            shift_r    <= '0;
            adc_l      <= '0;
            adc_r      <= '0;
        end else if (!enable) begin
            div_cnt    <= '0;
            bit_cnt    <= '0;
            aud_bclk   <= 1'b0;
            lrck       <= 1'b0;
            aud_dacdat <= 1'b0;
            sample_req <= 1'b0;
            sample_end <= 1'b0;
            hold_l     <= '0;
            hold_r     <= '0;
            shift_l    <= '0;
            shift_r    <= '0;
        end else begin
            div_cnt    <= div_nxt;
            bit_cnt    <= bit_nxt;
            aud_bclk   <= (div_nxt >= DIV_HALF);
            lrck       <= (bit_nxt >= SLOT);
            sample_req <= fe && (bit_nxt == BIT_LAST);
            sample_end <= frame_start;
            if (fe)
                aud_dacdat <= dac_nxt;
            if (frame_start) begin
                hold_l <= sample_in_l;
                hold_r <= sample_in_r;
                adc_l  <= shift_l;
                adc_r  <= shift_r;
            end
            if (rise_cap) begin
                if (bit_cnt >= SLOT)
                    shift_r <= {shift_r[SAMPLE_BITS-2:0], aud_adcdat};
                else
                    shift_l <= {shift_l[SAMPLE_BITS-2:0], aud_adcdat};
            end
        end
    end

endmodule

// File: doc/audio_codec_serializer.md
Name: audio_codec_serializer

Overview:
- Downstream stage of the audio sample source: the codec-side serial interface for the board audio codec (I2S slave).
- Generates the codec bit clock and LR clocks from the system clock.
- Issues a one-cycle sample_req ahead of each frame and serializes the returned 16-bit left/right samples onto the DAC data line.
- Deserializes the ADC data line into 16-bit left/right words and flags each completed frame with sample_end.

Parameters:
BCLK_DIV, 4, clk cycles per aud_bclk period; even, >= 2
SLOT_BITS, 32, aud_bclk periods per channel slot; >= 18
SAMPLE_BITS, 16, sample width; fixed at 16 in this revision

Ports:
clk  in  1  system/audio clock
reset  in  1  asynchronous, active-high reset
enable  in  1  run when 1; when 0, counters are held at zero and outputs are idle
sample_in_l  in  16  left DAC sample, two's complement; must be valid by the clk after sample_req
sample_in_r  in  16  right DAC sample, same timing as sample_in_l
sample_req  out  1  one-clk pulse requesting the next DAC sample pair
sample_end  out  1  one-clk pulse; adc_l/adc_r updated this cycle
adc_l  out  16  last captured left ADC sample
adc_r  out  16  last captured right ADC sample
aud_bclk  out  1  codec bit clock
aud_daclrck  out  1  DAC LR clock; 0 = left slot
aud_adclrck  out  1  ADC LR clock; identical to aud_daclrck
aud_dacdat  out  1  serial DAC data
aud_adcdat  in  1  serial ADC data; treated as synchronous to aud_bclk

Behaviour:
- Reset (async, any time, including mid-frame): every output and internal register is 0: aud_bclk, LR clocks, aud_dacdat, sample_req, sample_end, adc_l, adc_r, shift and hold registers, div_cnt, bit_cnt. The first frame after reset transmits zeros.
- div_cnt: 0..BCLK_DIV-1, wraps. aud_bclk = 0 while div_cnt < BCLK_DIV/2, else 1. All outputs are registered and glitch-free.
- Falling-edge event (FE): the cycle in which div_cnt wraps to 0. bit_cnt (0..2*SLOT_BITS-1) advances on FE and wraps.
- LR clock = (bit_cnt >= SLOT_BITS). DAC and ADC LR clocks always match.
- Frame start F: the FE on which bit_cnt becomes 0. sample_req pulses exactly BCLK_DIV clk cycles before F, i.e. on the FE into bit 2*SLOT_BITS-1.
- Sample latch: sample_in_l and sample_in_r are latched into hold registers at F. Inputs may change freely after F.
- DAC format (I2S, one-bit delay): aud_dacdat changes only at FE.
  - Left slot: position 0 outputs 0; positions 1..16 output left[15..0], MSB first; positions 17..SLOT_BITS-1 output 0.
  - Right slot: same layout with right[15..0], at bit_cnt SLOT_BITS+1..SLOT_BITS+16.
- ADC capture: aud_adcdat is sampled on the rising-edge cycle (div_cnt == BCLK_DIV/2) for slot positions 1..16, MSB first, into left and right shift registers.
  - At F, the completed words are copied to adc_l and adc_r, and sample_end pulses in the same cycle.
  - The first F after reset or enable still pulses sample_end; that frame's data is 0 or partial.
- enable deasserted: synchronous clear of div_cnt, bit_cnt, shifters and outputs to their reset values on the next clk. No pulses are issued while disabled. adc_l/adc_r hold their last values.
- enable reasserted: timing restarts from bit_cnt 0, exactly as after reset.
- sample_req and sample_end never coincide; they are BCLK_DIV cycles apart.
- Frame period = 2*SLOT_BITS*BCLK_DIV clk cycles (256 with defaults).

Optional Feature:
LEFT_JUSTIFIED_EN
- Defined: left-justified format. Slot positions 0..15 carry data MSB first, positions 16..SLOT_BITS-1 carry 0. ADC capture positions shift identically. LR polarity unchanged.
- Undefined: I2S format with one-bit delay, as specified above.

Test Plan:
- Defaults, enable=1, reset released at t0 -> first sample_req at clk t0+252; sample_end at t0+256; both then repeat every 256 clks; aud_bclk period 4 clks; LR clock toggles every 128 clks.
- Return sample_in_l=16'hA5C3, sample_in_r=16'h0F0F the cycle after sample_req -> next frame: dacdat bits 1..16 = 1010010111000011, bits 33..48 = 0000111100001111, all other bits 0.
- Loopback aud_adcdat=aud_dacdat with constant inputs A5C3/0F0F -> after the second sample_end: adc_l=16'hA5C3, adc_r=16'h0F0F.
- Negative full-scale sample_in_l=16'h8000 -> dacdat bit 1 = 1, bits 2..16 = 0; loopback adc_l=16'h8000.
- Pull enable low at bit_cnt 40 -> next clk: aud_bclk=0, LR=0, dacdat=0, no pulses, adc_l/adc_r held. Re-enable -> sample_req 252 clks later.
- Assert reset asynchronously mid-right-slot -> all outputs 0 immediately, without waiting for a clk edge. With LEFT_JUSTIFIED_EN defined, the 16'hA5C3 test places the MSB at slot position 0.
